// File: rtl/execute_stage.sv
// Execute stage: ALU, branch/memory address generation and registered hand-off
// of the instruction, its destination register and branch condition to the next stage.
module execute_stage #(
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable_execute,
  input  logic [DW-1:0] IR,
  input  logic [5:0]    E_Control,
  input  logic [DW-1:0] npc_in,
  input  logic          Mem_Control_in,
  input  logic [1:0]    W_Control_in,
  input  logic [DW-1:0] VSR1,
  input  logic [DW-1:0] VSR2,
  output logic [DW-1:0] aluout,
  output logic [DW-1:0] pcout,
  output logic [DW-1:0] M_Data,
  output logic [DW-1:0] IR_Exec,
  output logic [2:0]    dr,
  output logic [2:0]    NZP,
  output logic [1:0]    W_Control_out,
  output logic          Mem_Control_out,
  output logic [2:0]    sr1,
  output logic [2:0]    sr2
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  logic [3:0]           opcode;
  logic [1:0]           alu_control;
  logic [1:0]           pcselect1;
  logic                 pcselect2;
  logic                 op2select;
  logic signed [DW-1:0] imm5_sx;
  logic signed [DW-1:0] offset6_sx;
  logic signed [DW-1:0] offset9_sx;
  logic signed [DW-1:0] offset11_sx;
  logic signed [DW-1:0] op2;
  logic signed [DW-1:0] alu_res;
  logic signed [DW-1:0] addr_offset;
  logic signed [DW-1:0] addr_base;
  logic signed [DW-1:0] addr;
  logic                 is_alu_op;
  logic                 writes_dr;

  logic [DW-1:0] aluout_d, aluout_q;
  logic [DW-1:0] pcout_d, pcout_q;
  logic [DW-1:0] m_data_d, m_data_q;
  logic [DW-1:0] ir_exec_d, ir_exec_q;
  logic [2:0]    dr_d, dr_q;
  logic [2:0]    nzp_d, nzp_q;
  logic [1:0]    w_control_d, w_control_q;
  logic          mem_control_d, mem_control_q;

  assign opcode = IR[15:12];
  assign {alu_control, pcselect1, pcselect2, op2select} = E_Control;

  assign imm5_sx     = {{(DW-5){IR[4]}}, IR[4:0]};
  assign offset6_sx  = {{(DW-6){IR[5]}}, IR[5:0]};
  assign offset9_sx  = {{(DW-9){IR[8]}}, IR[8:0]};
  assign offset11_sx = {{(DW-11){IR[10]}}, IR[10:0]};

  always_comb begin
    op2 = op2select ? VSR2 : imm5_sx;
    case (alu_control)
      2'b00:   alu_res = VSR1 + op2;
      2'b01:   alu_res = VSR1 & op2;
      2'b10:   alu_res = ~VSR1;
      default: alu_res = VSR1;
    endcase
    case (pcselect1)
      2'b00:   addr_offset = offset11_sx;
      2'b01:   addr_offset = offset9_sx;
      2'b10:   addr_offset = offset6_sx;
      default: addr_offset = '0;
    endcase
    addr_base = pcselect2 ? npc_in : VSR1;
    addr      = addr_offset + addr_base;
  end

  always_comb begin
    is_alu_op = (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_NOT);
    writes_dr = is_alu_op || (opcode == OP_LD) || (opcode == OP_LDR) ||
                (opcode == OP_LDI) || (opcode == OP_LEA);
    sr1 = IR[8:6];
    if ((opcode == OP_BR) || (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_LEA))
      sr1 = 3'd0;
    sr2 = 3'd0;
    if ((opcode == OP_ADD) || (opcode == OP_AND))
      sr2 = IR[2:0];
    else if ((opcode == OP_ST) || (opcode == OP_STR) || (opcode == OP_STI))
      sr2 = IR[11:9];
  end

  // A stall holds everything but NZP, which drops so a branch resolves only once.
  always_comb begin
    aluout_d      = aluout_q;
    pcout_d       = pcout_q;
    m_data_d      = m_data_q;
    ir_exec_d     = ir_exec_q;
    dr_d          = dr_q;
    nzp_d         = 3'b000;
    w_control_d   = w_control_q;
    mem_control_d = mem_control_q;
    if (enable_execute) begin
      pcout_d       = addr;
      aluout_d      = is_alu_op ? alu_res : addr;
      m_data_d      = VSR2;
      ir_exec_d     = IR;
      dr_d          = writes_dr ? IR[11:9] : 3'd0;
      w_control_d   = W_Control_in;
      mem_control_d = Mem_Control_in;
      if (opcode == OP_BR)
        nzp_d = IR[11:9];
      else if (opcode == OP_JMP)
        nzp_d = 3'b111;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      aluout_q      <= '0;
      pcout_q       <= '0;
      m_data_q      <= '0;
      ir_exec_q     <= '0;
      dr_q          <= '0;
      nzp_q         <= '0;
      w_control_q   <= '0;
      mem_control_q <= 1'b0;
    end else begin
      aluout_q      <= aluout_d;
      pcout_q       <= pcout_d;
      m_data_q      <= m_data_d;
      ir_exec_q     <= ir_exec_d;
      dr_q          <= dr_d;
      nzp_q         <= nzp_d;
      w_control_q   <= w_control_d;
      mem_control_q <= mem_control_d;
    end
  end

  assign aluout          = aluout_q;
  assign pcout           = pcout_q;
  assign M_Data          = m_data_q;
  assign IR_Exec         = ir_exec_q;
  assign dr              = dr_q;
  assign NZP             = nzp_q;
  assign W_Control_out   = w_control_q;
  assign Mem_Control_out = mem_control_q;

endmodule

// File: tb/tb_execute_stage.sv
// Randomized bench for execute_stage against an instruction-level reference model,
// preceded by the directed vectors for reset, ADD/AND/BR/LDR and wrap-around.
module tb_execute_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_execute;
  logic [15:0] IR;
  logic [5:0]  E_Control;
  logic [15:0] npc_in;
  logic        Mem_Control_in;
  logic [1:0]  W_Control_in;
  logic [15:0] VSR1, VSR2;
  logic [15:0] aluout, pcout, M_Data, IR_Exec;
  logic [2:0]  dr, NZP, sr1, sr2;
  logic [1:0]  W_Control_out;
  logic        Mem_Control_out;

  always #5 clock = ~clock;

  execute_stage #(.DW(16)) dut (
    .clock(clock), .reset(reset), .enable_execute(enable_execute), .IR(IR),
    .E_Control(E_Control), .npc_in(npc_in), .Mem_Control_in(Mem_Control_in),
    .W_Control_in(W_Control_in), .VSR1(VSR1), .VSR2(VSR2), .aluout(aluout),
    .pcout(pcout), .M_Data(M_Data), .IR_Exec(IR_Exec), .dr(dr), .NZP(NZP),
    .W_Control_out(W_Control_out), .Mem_Control_out(Mem_Control_out),
    .sr1(sr1), .sr2(sr2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Architectural view of the stage's output registers.
  logic [15:0] m_alu, m_pc, m_md, m_ir;
  logic [2:0]  m_dr, m_nzp;
  logic [1:0]  m_w;
  logic        m_mem;

  function automatic bit op_in(input int op, input int list[]);
    foreach (list[i]) if (list[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] ref_sr1(input logic [15:0] ir);
    int op = int'(ir[15:12]);
    if (op_in(op, '{0, 2, 10, 14})) return 3'd0;
    return ir[8:6];
  endfunction

  function automatic logic [2:0] ref_sr2(input logic [15:0] ir);
    int op = int'(ir[15:12]);
    if (op_in(op, '{1, 5})) return ir[2:0];
    if (op_in(op, '{3, 7, 11})) return ir[11:9];
    return 3'd0;
  endfunction

  task automatic model_edge();
    int op, v1, opnd, off, base, alu, ad;
    if (reset) begin
      m_alu = 0; m_pc = 0; m_md = 0; m_ir = 0; m_dr = 0; m_nzp = 0; m_w = 0; m_mem = 0;
    end else if (!enable_execute) begin
      m_nzp = 3'b000;
    end else begin
      op   = int'(IR[15:12]);
      v1   = int'(VSR1);
      opnd = E_Control[0] ? int'(VSR2) : int'($signed(IR[4:0]));
      case (E_Control[5:4])
        2'd0:    alu = v1 + opnd;
        2'd1:    alu = v1 & opnd;
        2'd2:    alu = ~v1;
        default: alu = v1;
      endcase
      case (E_Control[3:2])
        2'd0:    off = int'($signed(IR[10:0]));
        2'd1:    off = int'($signed(IR[8:0]));
        2'd2:    off = int'($signed(IR[5:0]));
        default: off = 0;
      endcase
      base  = E_Control[1] ? int'(npc_in) : v1;
      ad    = (off + base) % 65536;
      if (ad < 0) ad += 65536;
      m_pc  = 16'(ad);
      m_alu = op_in(op, '{1, 5, 9}) ? 16'(alu) : 16'(ad);
      m_md  = VSR2;
      m_ir  = IR;
      m_w   = W_Control_in;
      m_mem = Mem_Control_in;
      m_dr  = op_in(op, '{1, 5, 9, 2, 6, 10, 14}) ? IR[11:9] : 3'd0;
      m_nzp = (op == 0) ? IR[11:9] : ((op == 12) ? 3'b111 : 3'b000);
    end
  endtask

  task automatic check_regs();
    chk("aluout", aluout, m_alu);
    chk("pcout", pcout, m_pc);
    chk("M_Data", M_Data, m_md);
    chk("IR_Exec", IR_Exec, m_ir);
    chk("dr", 16'(dr), 16'(m_dr));
    chk("NZP", 16'(NZP), 16'(m_nzp));
    chk("W_Control_out", 16'(W_Control_out), 16'(m_w));
    chk("Mem_Control_out", 16'(Mem_Control_out), 16'(m_mem));
  endtask

  // Inputs settle, source selects are checked, then one clock edge is taken.
  task automatic cycle();
    #1;
    chk("sr1", 16'(sr1), 16'(ref_sr1(IR)));
    chk("sr2", 16'(sr2), 16'(ref_sr2(IR)));
    model_edge();
    @(posedge clock);
    #1;
    check_regs();
  endtask

  task automatic randomize_inputs();
    IR             = 16'($urandom);
    E_Control      = 6'($urandom);
    npc_in         = 16'($urandom);
    Mem_Control_in = 1'($urandom);
    W_Control_in   = 2'($urandom);
    VSR1           = 16'($urandom);
    VSR2           = 16'($urandom);
  endtask

  initial begin
    randomize_inputs();
    reset = 1'b1;
    enable_execute = 1'b1;
    cycle();
    randomize_inputs();
    cycle();
    chk("reset_aluout", aluout, 16'h0000);
    chk("reset_nzp", 16'(NZP), 16'h0000);

    reset = 1'b0;
    IR = 16'h1261; E_Control = 6'b000000; VSR1 = 16'h0005; enable_execute = 1'b1;
    cycle();
    chk("add_aluout", aluout, 16'h0006);
    chk("add_dr", 16'(dr), 16'd1);
    chk("add_sr1", 16'(sr1), 16'd1);

    IR = 16'h5442; E_Control = 6'b010001; VSR1 = 16'h00F0; VSR2 = 16'h0FF0;
    cycle();
    chk("and_aluout", aluout, 16'h00F0);
    chk("and_sr2", 16'(sr2), 16'd2);
    chk("and_mdata", M_Data, 16'h0FF0);

    IR = 16'h0E05; E_Control = 6'b000110; npc_in = 16'h3001;
    cycle();
    chk("br_pcout", pcout, 16'h3006);
    chk("br_nzp", 16'(NZP), 16'h0007);
    enable_execute = 1'b0;
    randomize_inputs();
    cycle();
    chk("stall_nzp", 16'(NZP), 16'h0000);
    chk("stall_pcout", pcout, 16'h3006);

    enable_execute = 1'b1;
    IR = 16'h6A7F; E_Control = 6'b001000; VSR1 = 16'h4000; W_Control_in = 2'd1;
    cycle();
    chk("ldr_aluout", aluout, 16'h3FFF);
    chk("ldr_pcout", pcout, 16'h3FFF);
    chk("ldr_dr", 16'(dr), 16'd5);

    IR = 16'h1021; E_Control = 6'b000000; VSR1 = 16'hFFFF;
    cycle();
    chk("wrap_aluout", aluout, 16'h0000);
    IR = 16'h1261; VSR1 = 16'h1234; reset = 1'b1;
    cycle();
    chk("midreset_pcout", pcout, 16'h0000);
    chk("midreset_ir", IR_Exec, 16'h0000);
    reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      reset          = ($urandom_range(0, 19) == 0);
      enable_execute = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
